// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot grants, owner hold while requesting,
// and an optional hold limit that forces rotation when others are waiting.
module rr_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    parameter int ID_W     = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_id,
    output logic            busy,
    output logic            timeout
);

    localparam int              HC_W      = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HC_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HC_W'(MAX_HOLD - 1) : '0;
    localparam bit              LIMIT_EN  = (MAX_HOLD > 0);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state, state_nxt;
    logic [ID_W-1:0] ptr, ptr_nxt;
    logic [HC_W-1:0] hold_cnt, hold_cnt_nxt;
    logic [N-1:0]    gnt_nxt;
    logic [ID_W-1:0] gnt_id_nxt;
    logic            busy_nxt;
    logic            timeout_nxt;
    logic [ID_W-1:0] win;
    logic [N-1:0]    owner_mask;
    logic [N-1:0]    others_req;
    logic            owner_req;

    // First set candidate scanning upward from start, wrapping modulo N.
    function automatic logic [ID_W-1:0] pick(input logic [N-1:0] cand,
                                             input logic [ID_W-1:0] start);
        logic [ID_W-1:0] w;
        logic            found;
        int              idx;
        w     = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(start) + k) % N;
            if (!found && cand[idx]) begin
                w     = ID_W'(idx);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] o);
        return (int'(o) == N - 1) ? '0 : o + 1'b1;
    endfunction

    function automatic logic [N-1:0] onehot(input logic [ID_W-1:0] w);
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) begin
            v[i] = (i == int'(w));
        end
        return v;
    endfunction

    assign owner_mask = onehot(gnt_id);
    assign others_req = req & ~owner_mask;
    assign owner_req  = |(req & owner_mask);

    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        hold_cnt_nxt = hold_cnt;
        gnt_nxt      = gnt;
        gnt_id_nxt   = gnt_id;
        busy_nxt     = busy;
        timeout_nxt  = 1'b0;
        win          = '0;
        case (state)
            IDLE: begin
                if (|req) begin
                    win          = pick(req, ptr);
                    state_nxt    = GRANT;
                    gnt_nxt      = onehot(win);
                    gnt_id_nxt   = win;
                    busy_nxt     = 1'b1;
                    hold_cnt_nxt = '0;
                end
            end
            GRANT: begin
                if (!owner_req) begin
                    ptr_nxt      = next_idx(gnt_id);
                    hold_cnt_nxt = '0;
                    if (|others_req) begin
                        // Hand over directly so the resource never sees an idle bubble.
                        win        = pick(req, next_idx(gnt_id));
                        gnt_nxt    = onehot(win);
                        gnt_id_nxt = win;
                    end else begin
                        state_nxt  = IDLE;
                        gnt_nxt    = '0;
                        gnt_id_nxt = '0;
                        busy_nxt   = 1'b0;
                    end
                end else if (LIMIT_EN && (hold_cnt == HOLD_LAST) && (|others_req)) begin
                    ptr_nxt      = next_idx(gnt_id);
                    win          = pick(others_req, next_idx(gnt_id));
                    gnt_nxt      = onehot(win);
                    gnt_id_nxt   = win;
                    timeout_nxt  = 1'b1;
                    hold_cnt_nxt = '0;
                end else if (hold_cnt != HOLD_LAST) begin
                    hold_cnt_nxt = hold_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt  = IDLE;
                gnt_nxt    = '0;
                gnt_id_nxt = '0;
                busy_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            gnt      <= '0;
            gnt_id   <= '0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            hold_cnt <= hold_cnt_nxt;
            gnt      <= gnt_nxt;
            gnt_id   <= gnt_id_nxt;
            busy     <= busy_nxt;
            timeout  <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter: one instance with a hold limit of 8, one with the limit disabled.
module tb_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       timeout;

    logic [3:0] req_nl;
    logic [3:0] gnt_nl;
    logic [1:0] gnt_id_nl;
    logic       busy_nl;
    logic       timeout_nl;

    int vectors;
    int miscompares;
    logic prev_to;
    logic prev_to_nl;

    rr_arbiter #(.N(4), .MAX_HOLD(8), .ID_W(2)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt), .gnt_id(gnt_id),
        .busy(busy), .timeout(timeout)
    );

    rr_arbiter #(.N(4), .MAX_HOLD(0), .ID_W(2)) dut_nl (
        .clk(clk), .rst(rst), .req(req_nl), .gnt(gnt_nl), .gnt_id(gnt_id_nl),
        .busy(busy_nl), .timeout(timeout_nl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] id,
                              input logic b, input logic to);
        chk({tag, ".gnt"}, 32'(gnt), 32'(g));
        if (b) chk({tag, ".gnt_id"}, 32'(gnt_id), 32'(id));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
        chk({tag, ".timeout"}, 32'(timeout), 32'(to));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        expect_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        chk("reset.gnt_id", 32'(gnt_id), 32'd0);
        rst = 1'b0;
    endtask

    // Structural invariants on both instances, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            chk("inv.onehot", 32'($onehot0(gnt)), 32'd1);
            chk("inv.busy", 32'(busy), 32'(|gnt));
            if (busy) chk("inv.gnt_id", 32'(gnt[gnt_id]), 32'd1);
            chk("inv.to_pulse", 32'(prev_to & timeout), 32'd0);
            chk("inv_nl.onehot", 32'($onehot0(gnt_nl)), 32'd1);
            chk("inv_nl.busy", 32'(busy_nl), 32'(|gnt_nl));
            if (busy_nl) chk("inv_nl.gnt_id", 32'(gnt_nl[gnt_id_nl]), 32'd1);
            chk("inv_nl.to_pulse", 32'(prev_to_nl & timeout_nl), 32'd0);
        end
        prev_to    <= rst ? 1'b0 : timeout;
        prev_to_nl <= rst ? 1'b0 : timeout_nl;
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        req         = 4'b0000;
        req_nl      = 4'b0000;
        #2;
        chk("reset_async.gnt", 32'(gnt), 32'd0);
        tick();
        tick();
        do_reset();

        // Single requester
        req = 4'b0001;
        tick();
        expect_out("single.grant", 4'b0001, 2'd0, 1'b1, 1'b0);
        req = 4'b0000;
        tick();
        expect_out("single.release", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Simultaneous requests from IDLE after reset
        do_reset();
        req = 4'b1010;
        tick();
        expect_out("simul.first", 4'b0010, 2'd1, 1'b1, 1'b0);
        req = 4'b1000;
        tick();
        expect_out("simul.handover", 4'b1000, 2'd3, 1'b1, 1'b0);
        req = 4'b0000;
        tick();
        expect_out("simul.idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Fairness: each owner holds 3 cycles then drops for one
        do_reset();
        req = 4'b1111;
        tick();
        for (int k = 0; k < 4; k++) begin
            expect_out($sformatf("fair.own%0d.c1", k), 4'(1 << k), 2'(k), 1'b1, 1'b0);
            tick();
            expect_out($sformatf("fair.own%0d.c2", k), 4'(1 << k), 2'(k), 1'b1, 1'b0);
            tick();
            expect_out($sformatf("fair.own%0d.c3", k), 4'(1 << k), 2'(k), 1'b1, 1'b0);
            req = 4'b1111 & ~4'(1 << k);
            tick();
            req = 4'b1111;
        end
        expect_out("fair.wrap0", 4'b0001, 2'd0, 1'b1, 1'b0);
        req = 4'b0000;
        tick();
        expect_out("fair.idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Hold limit with a contender arriving at cycle 2
        do_reset();
        req = 4'b0001;
        tick();
        expect_out("limit.c1", 4'b0001, 2'd0, 1'b1, 1'b0);
        tick();
        req = 4'b0101;
        for (int c = 2; c <= 8; c++) begin
            if (c > 2) tick();
            expect_out($sformatf("limit.c%0d", c), 4'b0001, 2'd0, 1'b1, 1'b0);
        end
        tick();
        expect_out("limit.rotate", 4'b0100, 2'd2, 1'b1, 1'b1);
        tick();
        expect_out("limit.after", 4'b0100, 2'd2, 1'b1, 1'b0);
        req = 4'b0001;
        tick();
        expect_out("limit.back0", 4'b0001, 2'd0, 1'b1, 1'b0);
        req = 4'b0000;
        tick();
        expect_out("limit.idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Limit reached with no contender, then one appears
        do_reset();
        req = 4'b0001;
        for (int c = 1; c <= 20; c++) begin
            tick();
            expect_out($sformatf("solo.c%0d", c), 4'b0001, 2'd0, 1'b1, 1'b0);
        end
        req = 4'b0011;
        tick();
        expect_out("solo.rotate", 4'b0010, 2'd1, 1'b1, 1'b1);
        tick();
        expect_out("solo.after", 4'b0010, 2'd1, 1'b1, 1'b0);
        req = 4'b0000;
        tick();

        // Limit disabled: owner keeps the grant indefinitely
        do_reset();
        req_nl = 4'b0011;
        for (int c = 1; c <= 12; c++) begin
            tick();
            chk($sformatf("nolimit.gnt.c%0d", c), 32'(gnt_nl), 32'b0001);
            chk($sformatf("nolimit.to.c%0d", c), 32'(timeout_nl), 32'd0);
        end
        req_nl = 4'b0010;
        tick();
        chk("nolimit.release.gnt", 32'(gnt_nl), 32'b0010);
        chk("nolimit.release.id", 32'(gnt_id_nl), 32'd1);
        req_nl = 4'b0000;
        tick();
        chk("nolimit.idle", 32'(busy_nl), 32'd0);

        // Asynchronous reset mid-grant
        do_reset();
        req = 4'b0100;
        tick();
        expect_out("areset.pre", 4'b0100, 2'd2, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        expect_out("areset.immediate", 4'b0000, 2'd0, 1'b0, 1'b0);
        req = 4'b0110;
        #1;
        rst = 1'b0;
        tick();
        expect_out("areset.ptr0", 4'b0010, 2'd1, 1'b1, 1'b0);
        req = 4'b0000;
        tick();
        expect_out("areset.idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
